// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioner: per-channel FSM encoding
// and the default timing constants for a 25 MHz pixel clock.
package button_pkg;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t IDLE      = 2'd0;
    localparam btn_state_t WAIT_HIGH = 2'd1;
    localparam btn_state_t HELD      = 2'd2;
    localparam btn_state_t WAIT_LOW  = 2'd3;

    localparam int DEBOUNCE_10MS = 250_000;
    localparam int REPEAT_500MS  = 12_500_000;
    localparam int REPEAT_100MS  = 2_500_000;
    localparam int DEFAULT_CNT_W = 24;

    // The debounced level is high in both the held and the pending-release states.
    function automatic logic is_pressed_state(input btn_state_t s);
        return (s == HELD) || (s == WAIT_LOW);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: two-flop synchroniser, debounce/repeat FSM and registered
// level and strobe outputs.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int REPEAT_DELAY    = REPEAT_500MS,
    parameter int REPEAT_PERIOD   = REPEAT_100MS,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic             sync1_q, sync2_q;
    logic             sync;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             rep_armed_q, rep_armed_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;
    logic [CNT_W-1:0] rep_limit;
    logic             rep_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign sync = sync2_q;

    // rep_armed_q selects the long first delay versus the shorter steady period.
    assign rep_limit = rep_armed_q ? PER_LAST : DLY_LAST;
    assign rep_hit   = (state_q == HELD) && sync && (rcnt_q == rep_limit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            dcnt_q      <= '0;
            rcnt_q      <= '0;
            rep_armed_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            rcnt_q      <= rcnt_d;
            rep_armed_q <= rep_armed_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        rcnt_d      = rcnt_q;
        rep_armed_d = rep_armed_q;
        case (state_q)
            IDLE: begin
                if (sync) begin
                    state_d = WAIT_HIGH;
                    dcnt_d  = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync) begin
                    state_d = IDLE;
                end else if (dcnt_q == DB_LAST) begin
                    state_d     = HELD;
                    rcnt_d      = '0;
                    rep_armed_d = 1'b0;
                end else begin
                    dcnt_d = sat_inc(dcnt_q);
                end
            end
            HELD: begin
                if (!sync) begin
                    // rcnt is left untouched so a short release glitch resumes the repeat timing
                    state_d = WAIT_LOW;
                    dcnt_d  = '0;
                end else if (rep_hit) begin
                    rcnt_d      = '0;
                    rep_armed_d = 1'b1;
                end else begin
                    rcnt_d = sat_inc(rcnt_q);
                end
            end
            WAIT_LOW: begin
                if (sync) begin
                    state_d = HELD;
                end else if (dcnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    dcnt_d = sat_inc(dcnt_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        level_d   = is_pressed_state(state_d);
        press_d   = (state_q == WAIT_HIGH) && (state_d == HELD);
        release_d = (state_q == WAIT_LOW) && (state_d == IDLE);
        repeat_d  = rep_hit;
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: NUM_BTN independent debounce channels
// producing clean levels plus press, release and auto-repeat strobes.
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int REPEAT_DELAY    = REPEAT_500MS,
    parameter int REPEAT_PERIOD   = REPEAT_100MS,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            button_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_PERIOD  (REPEAT_PERIOD),
                .CNT_W          (CNT_W)
            ) u_chan (
                .clk      (clk),
                .reset_n  (reset_n),
                .btn_raw_i(btn_raw[gi]),
                .level_o  (btn_level[gi]),
                .press_o  (btn_press[gi]),
                .release_o(btn_release[gi]),
                .repeat_o (btn_repeat[gi])
            );
        end
    endgenerate

endmodule
